// File: rtl/rx_slicer_ber_pkg.sv
// Shared definitions for the receive slicer/BER block: PRBS9 taps and seed,
// alignment FSM encoding, and the (18,15) sample format.
package rx_slicer_ber_pkg;

  localparam int PRBS_ORDER  = 9;
  localparam int PRBS_TAP_HI = 8;  // x^9 term
  localparam int PRBS_TAP_LO = 4;  // x^5 term
  localparam logic [PRBS_ORDER-1:0] PRBS_SEED_DEFAULT = 9'h1AB;

  localparam int SAMPLE_NBI = 3;
  localparam int SAMPLE_NBF = 15;
  localparam int SAMPLE_NB  = SAMPLE_NBI + SAMPLE_NBF;

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  function automatic logic [PRBS_ORDER-1:0] prbs9_next(input logic [PRBS_ORDER-1:0] r);
    return {r[PRBS_ORDER-2:0], r[PRBS_TAP_HI] ^ r[PRBS_TAP_LO]};
  endfunction

endpackage

// File: rtl/rx_slicer_ber_prbs9_gen.sv
// PRBS9 (x^9+x^5+1) generator shared by the transmit and receive paths.
// Loads i_seed on reset and advances one step per cycle while i_enable is high.
module prbs9_gen
  import rx_slicer_ber_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_enable,
  input  logic [PRBS_ORDER-1:0] i_seed,
  output logic                  o_bit
);

  logic [PRBS_ORDER-1:0] r_lfsr;

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lfsr <= i_seed;
    end else if (i_enable) begin
      r_lfsr <= prbs9_next(r_lfsr);
    end
  end

  assign o_bit = r_lfsr[PRBS_ORDER-1];

endmodule

// File: rtl/rx_slicer_ber.sv
// Decimating hard slicer with PRBS9 alignment and bit-error counting.
// Build option: define RX_BER_CNT_SAT_EN for saturating counters (default wraps).
module rx_slicer_ber
  import rx_slicer_ber_pkg::*;
#(
  parameter int                    NB_INPUT  = SAMPLE_NB,
  parameter int                    OS_FACTOR = 4,
  parameter int                    NB_PHASE  = 2,
  parameter int                    WIN_LEN   = 511,
  parameter int                    NB_CNT    = 32,
  parameter logic [PRBS_ORDER-1:0] PRBS_SEED = PRBS_SEED_DEFAULT
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_valid,
  input  logic [NB_INPUT-1:0] i_data,
  input  logic                i_enable,
  input  logic [NB_PHASE-1:0] i_phase,
  output logic                o_bit,
  output logic                o_bit_valid,
  output logic                o_locked,
  output logic [NB_CNT-1:0]   o_bit_cnt,
  output logic [NB_CNT-1:0]   o_err_cnt
);

  localparam int                NB_WIN     = $clog2(WIN_LEN + 1);
  localparam logic [NB_WIN-1:0] WIN_LAST   = NB_WIN'(WIN_LEN - 1);
  localparam logic [NB_WIN-1:0] ERR_THRESH = NB_WIN'(WIN_LEN / 4);
  localparam logic [NB_PHASE-1:0] PH_LAST  = NB_PHASE'(OS_FACTOR - 1);

  state_t              r_state;
  state_t              w_state_next;
  logic [NB_PHASE-1:0] r_phase_cnt;
  logic [NB_WIN-1:0]   r_win_cnt;
  logic [NB_WIN-1:0]   r_win_err;
  logic                r_slip;
  logic                r_bit;
  logic                r_bit_valid;
  logic                r_locked;
  logic [NB_CNT-1:0]   r_bit_cnt;
  logic [NB_CNT-1:0]   r_err_cnt;

  logic                w_step;
  logic                w_decision;
  logic                w_slice;
  logic                w_ref;
  logic                w_compare;
  logic                w_mismatch;
  logic                w_win_end;
  logic [NB_WIN-1:0]   w_win_err_tot;
  logic                w_slip_set;
  logic                w_cnt_clear;
  logic [NB_CNT-1:0]   w_bit_cnt_next;
  logic [NB_CNT-1:0]   w_err_cnt_next;
  logic                w_unused_lsbs;

  assign w_step     = i_valid & i_enable;
  assign w_decision = w_step & (r_phase_cnt == i_phase);
  assign w_slice    = i_data[NB_INPUT-1];

  // Only the sign bit is sliced; the magnitude bits are intentionally ignored.
  assign w_unused_lsbs = ^i_data[NB_INPUT-2:0];

  // A slip decision only holds the reference back; it is not compared or
  // counted, so the next window starts cleanly at the new offset.
  assign w_compare     = w_decision & ~r_slip;
  assign w_mismatch    = w_compare & (w_slice ^ w_ref);
  assign w_win_end     = w_compare & (r_win_cnt == WIN_LAST);
  assign w_win_err_tot = r_win_err + NB_WIN'(w_mismatch);

  prbs9_gen u_ref_prbs (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_enable (w_compare),
    .i_seed   (PRBS_SEED),
    .o_bit    (w_ref)
  );

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_slip_set   = 1'b0;
    w_cnt_clear  = 1'b0;
    if (w_win_end) begin
      case (r_state)
        ST_SEARCH: begin
          if (w_win_err_tot == '0) begin
            w_state_next = ST_LOCKED;
            w_cnt_clear  = 1'b1;
          end else begin
            w_slip_set = 1'b1;
          end
        end
        ST_LOCKED: begin
          if (w_win_err_tot > ERR_THRESH) begin
            w_state_next = ST_SEARCH;
          end
        end
        default: w_state_next = ST_SEARCH;
      endcase
    end
  end

  always_comb begin
    w_bit_cnt_next = r_bit_cnt;
    w_err_cnt_next = r_err_cnt;
    if (w_cnt_clear) begin
      w_bit_cnt_next = '0;
      w_err_cnt_next = '0;
    end else if (w_compare && (r_state == ST_LOCKED)) begin
`ifdef RX_BER_CNT_SAT_EN
      // Errors freeze with the bit count so the reported ratio stays meaningful.
      if (r_bit_cnt != '1) begin
        w_bit_cnt_next = r_bit_cnt + 1'b1;
        if (w_mismatch && (r_err_cnt != '1)) begin
          w_err_cnt_next = r_err_cnt + 1'b1;
        end
      end
`else
      w_bit_cnt_next = r_bit_cnt + 1'b1;
      if (w_mismatch) begin
        w_err_cnt_next = r_err_cnt + 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_SEARCH;
      r_phase_cnt <= '0;
      r_win_cnt   <= '0;
      r_win_err   <= '0;
      r_slip      <= 1'b0;
      r_bit       <= 1'b0;
      r_bit_valid <= 1'b0;
      r_locked    <= 1'b0;
      r_bit_cnt   <= '0;
      r_err_cnt   <= '0;
    end else if (i_enable) begin
      r_bit_valid <= w_decision;
      r_locked    <= (r_state == ST_LOCKED);
      r_state     <= w_state_next;
      r_bit_cnt   <= w_bit_cnt_next;
      r_err_cnt   <= w_err_cnt_next;
      if (w_step) begin
        r_phase_cnt <= (r_phase_cnt == PH_LAST) ? '0 : r_phase_cnt + 1'b1;
      end
      if (w_decision) begin
        r_bit <= w_slice;
      end
      if (w_decision && r_slip) begin
        r_slip <= 1'b0;
      end else if (w_slip_set) begin
        r_slip <= 1'b1;
      end
      if (w_win_end) begin
        r_win_cnt <= '0;
        r_win_err <= '0;
      end else if (w_compare) begin
        r_win_cnt <= r_win_cnt + 1'b1;
        r_win_err <= w_win_err_tot;
      end
    end else begin
      r_bit_valid <= 1'b0;
    end
  end

  assign o_bit       = r_bit;
  assign o_bit_valid = r_bit_valid;
  assign o_locked    = r_locked;
  assign o_bit_cnt   = r_bit_cnt;
  assign o_err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_rx_slicer_ber.sv
// Self-checking bench for rx_slicer_ber: randomized sample streams compared
// cycle by cycle against a decision-level reference model.
module tb_rx_slicer_ber;

  localparam int NB_INPUT = 18;
  localparam int OS       = 4;
  localparam int NB_PHASE = 2;
  localparam int WIN_LEN  = 511;
  localparam int NB_CNT   = 32;
  localparam int NB_CNT8  = 8;
  localparam logic [8:0] SEED = 9'h1AB;

  logic                       i_clk = 1'b0;
  logic                       i_rst;
  logic                       i_valid;
  logic signed [NB_INPUT-1:0] i_data;
  logic                       i_enable;
  logic [NB_PHASE-1:0]        i_phase;

  logic              o_bit, o_bit_valid, o_locked;
  logic [NB_CNT-1:0] o_bit_cnt, o_err_cnt;
  logic               o8_bit, o8_bit_valid, o8_locked;
  logic [NB_CNT8-1:0] o8_bit_cnt, o8_err_cnt;

  int checks = 0;
  int errors = 0;

  rx_slicer_ber #(.NB_INPUT(NB_INPUT), .OS_FACTOR(OS), .NB_PHASE(NB_PHASE),
                  .WIN_LEN(WIN_LEN), .NB_CNT(NB_CNT), .PRBS_SEED(SEED)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_data(i_data),
    .i_enable(i_enable), .i_phase(i_phase), .o_bit(o_bit),
    .o_bit_valid(o_bit_valid), .o_locked(o_locked),
    .o_bit_cnt(o_bit_cnt), .o_err_cnt(o_err_cnt));

  rx_slicer_ber #(.NB_INPUT(NB_INPUT), .OS_FACTOR(OS), .NB_PHASE(NB_PHASE),
                  .WIN_LEN(WIN_LEN), .NB_CNT(NB_CNT8), .PRBS_SEED(SEED)) dut8 (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_data(i_data),
    .i_enable(i_enable), .i_phase(i_phase), .o_bit(o8_bit),
    .o_bit_valid(o8_bit_valid), .o_locked(o8_locked),
    .o_bit_cnt(o8_bit_cnt), .o_err_cnt(o8_err_cnt));

  always #5 i_clk = ~i_clk;

  // Reference model: the PRBS is an indexed table, alignment is an index.
  bit     seq [WIN_LEN];
  int     m_pc, m_idx, m_wc, m_we;
  bit     m_state_locked, m_locked_q, m_slip, m_obit, m_obv;
  longint m_bits, m_errs;
  int     m_bits8, m_errs8;
  int     tx_k;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_idx = 0; m_wc = 0; m_we = 0;
    m_state_locked = 0; m_locked_q = 0; m_slip = 0; m_obit = 0; m_obv = 0;
    m_bits = 0; m_errs = 0; m_bits8 = 0; m_errs8 = 0;
  endtask

  task automatic model_step();
    bit dec, b, mism, was_locked;
    if (i_rst) begin
      model_reset();
      return;
    end
    if (!i_enable) begin
      m_obv = 0;
      return;
    end
    was_locked = m_state_locked;
    dec = i_valid && (m_pc == int'(i_phase));
    if (i_valid) m_pc = (m_pc + 1) % OS;
    m_locked_q = was_locked;
    m_obv = dec;
    if (!dec) return;
    b = (i_data < 0);
    m_obit = b;
    if (m_slip) begin
      m_slip = 0;
      return;
    end
    mism = (b != seq[m_idx]);
    m_idx = (m_idx + 1) % WIN_LEN;
    m_we += int'(mism);
    if (was_locked) begin
      m_bits++;
      m_errs += longint'(mism);
`ifdef RX_BER_CNT_SAT_EN
      if (m_bits8 != 255) begin
        m_bits8++;
        if (mism && m_errs8 != 255) m_errs8++;
      end
`else
      m_bits8 = (m_bits8 + 1) % 256;
      if (mism) m_errs8 = (m_errs8 + 1) % 256;
`endif
    end
    if (m_wc == WIN_LEN - 1) begin
      if (!was_locked) begin
        if (m_we == 0) begin
          m_state_locked = 1;
          m_bits = 0; m_errs = 0; m_bits8 = 0; m_errs8 = 0;
        end else begin
          m_slip = 1;
        end
      end else if (m_we > WIN_LEN / 4) begin
        m_state_locked = 0;
      end
      m_wc = 0;
      m_we = 0;
    end else begin
      m_wc++;
    end
  endtask

  task automatic check_all();
    check("bit_valid", o_bit_valid, m_obv);
    check("bit", o_bit, m_obit);
    check("locked", o_locked, m_locked_q);
    check("bit_cnt", o_bit_cnt, m_bits);
    check("err_cnt", o_err_cnt, m_errs);
    check("bit_cnt8", o8_bit_cnt, m_bits8);
    check("err_cnt8", o8_err_cnt, m_errs8);
  endtask

  task automatic cycle(input bit v, input logic signed [NB_INPUT-1:0] d);
    i_valid = v;
    i_data  = d;
    model_step();
    @(posedge i_clk);
    #1;
    check_all();
  endtask

  function automatic logic signed [NB_INPUT-1:0] level(input bit b);
    int v;
    v = (b ? -16384 : 16384) + $urandom_range(8000) - 4000;
    return NB_INPUT'(v);
  endfunction

  function automatic logic signed [NB_INPUT-1:0] rand_data();
    return NB_INPUT'($urandom);
  endfunction

  task automatic send_symbol(input bit b);
    for (int j = 0; j < OS; j++) begin
      while ($urandom_range(7) == 0) cycle(1'b0, rand_data());
      cycle(1'b1, (j == int'(i_phase)) ? level(b) : rand_data());
    end
  endtask

  task automatic send_stream(input int n, input int delay, input int flip_every, output int n_flip);
    bit b;
    n_flip = 0;
    for (int i = 0; i < n; i++) begin
      b = seq[((tx_k - delay) % WIN_LEN + WIN_LEN) % WIN_LEN];
      if (flip_every > 0 && (i % flip_every) == flip_every - 1) begin
        b = ~b;
        n_flip++;
      end
      send_symbol(b);
      tx_k++;
    end
  endtask

  task automatic pulse_reset();
    i_rst = 1'b1;
    cycle(1'b1, rand_data());
    i_rst = 1'b0;
    tx_k = 0;
  endtask

  initial begin
    logic [8:0] lfsr;
    int nf, delay;
    lfsr = SEED;
    for (int i = 0; i < WIN_LEN; i++) begin
      seq[i] = lfsr[8];
      lfsr = {lfsr[7:0], lfsr[8] ^ lfsr[4]};
    end
    model_reset();
    i_rst = 1'b1; i_enable = 1'b1; i_valid = 1'b0; i_data = '0; i_phase = '0; tx_k = 0;
    repeat (3) cycle(1'b1, rand_data());
    i_rst = 1'b0;
    check("rst_bit_valid", o_bit_valid, 1'b0);
    check("rst_locked", o_locked, 1'b0);
    check("rst_bit_cnt", o_bit_cnt, 0);
    check("rst_err_cnt", o_err_cnt, 0);

    // Loopback, zero offset, phase 0.
    send_stream(510, 0, 0, nf);
    check("loop_not_yet_locked", o_locked, 1'b0);
    send_stream(1, 0, 0, nf);
    check("loop_locked_at_511", o_locked, 1'b1);
    send_stream(9, 0, 0, nf);
    check("loop_bit_cnt", o_bit_cnt, 9);
    check("loop_err_cnt", o_err_cnt, 0);

    // Injected errors while locked: one flip per 100 bits.
    send_stream(1000, 0, 100, nf);
    check("inj_locked", o_locked, 1'b1);
    check("inj_err_cnt", o_err_cnt, nf);
    check("inj_bit_cnt", o_bit_cnt, 1009);

    // Loss of lock with constant +0.25 input.
    for (int i = 0; i < 600; i++) begin
      for (int j = 0; j < OS; j++) cycle(1'b1, 18'sd8192);
    end
    check("lol_unlocked", o_locked, 1'b0);

    // Offset stream with a phase change part way through the search.
    delay = $urandom_range(3, 8);
    i_phase = 2'd1;
    pulse_reset();
    send_stream(100, delay, 0, nf);
    i_phase = 2'd3;
    send_stream((delay + 1) * 512 + 20 - 100, delay, 0, nf);
    check("ofs_locked", o_locked, 1'b1);
    check("ofs_err_cnt", o_err_cnt, 0);

    // Hold mid-window, then reset mid-window.
    send_stream(100, delay, 0, nf);
    i_enable = 1'b0;
    repeat (50) cycle(1'($urandom), rand_data());
    check("hold_bit_valid", o_bit_valid, 1'b0);
    check("hold_locked", o_locked, 1'b1);
    i_enable = 1'b1;
    send_stream(50, delay, 0, nf);
    i_phase = 2'd0;
    pulse_reset();
    check("post_rst_bit", o_bit, 1'b0);
    check("post_rst_bit_valid", o_bit_valid, 1'b0);
    check("post_rst_locked", o_locked, 1'b0);
    check("post_rst_bit_cnt", o_bit_cnt, 0);
    check("post_rst_err_cnt", o_err_cnt, 0);
    send_stream(510, 0, 0, nf);
    check("relock_not_early", o_locked, 1'b0);
    send_stream(1, 0, 0, nf);
    check("relock_locked", o_locked, 1'b1);

    // 300 locked decisions against 32-bit and 8-bit counters.
    send_stream(300, 0, 0, nf);
    check("sat_bit_cnt32", o_bit_cnt, 300);
`ifdef RX_BER_CNT_SAT_EN
    check("sat_bit_cnt8", o8_bit_cnt, 255);
`else
    check("wrap_bit_cnt8", o8_bit_cnt, 44);
`endif
    check("sat_err_cnt8", o8_err_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
